// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// | Package     : uart_pkg                                                   |
// | Description : Shared types and constants for the UART word packer:       |
// |               rx FSM state encoding, byte-order selectors and the        |
// |               baud-counter terminal-count helper.                        |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
package uart_pkg;

  // Receiver FSM states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Byte-order selectors: where the first-arriving byte of a word lands
  localparam int BYTE_ORDER_MSB = 0;
  localparam int BYTE_ORDER_LSB = 1;

  // Terminal count of the per-bit clock counter (one bit = result+1 clocks)
  function automatic int bit_cnt_max(input int clk_freq, input int uart_bps);
    return (clk_freq / uart_bps) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// | Module      : uart_rx_core                                               |
// | Description : 8-bit UART receiver. 2-FF input synchronizer, baud counter |
// |               with mid-bit sampling, optional parity check. Emits a     |
// |               one-cycle byte_valid_o for good frames and one-cycle      |
// |               error pulses for bad stop bit / parity.                   |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int UART_BPS   = 9600,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       idle_o
);

  localparam int BIT_CNT_MAX = bit_cnt_max(CLK_FREQ, UART_BPS);
  localparam int CNT_W       = (BIT_CNT_MAX > 0) ? $clog2(BIT_CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BIT_CNT_MAX / 2);

  logic       rx_meta_q, rx_sync_q, rx_prev_q;
  logic       w_fall;

  rx_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       par_ok_q, par_ok_d;
  logic       valid_q, valid_d;
  logic       ferr_q, ferr_d;
  logic       perr_q, perr_d;

  // Synchronizer plus one history stage for falling-edge detection; line idles high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign w_fall = rx_prev_q & ~rx_sync_q;

  // FSM, counters and output pulse registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_ok_q  <= 1'b1;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_ok_q  <= par_ok_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  // Next-state: START waits half a bit to centre on the start bit, then full bits
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        par_ok_d  = 1'b1;
        if (w_fall) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          // A high line at the start-bit centre is a glitch: go back to idle
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d     = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY_EN ? RX_PARITY : RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_PARITY: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d    = '0;
          par_ok_d = (((^shift_q) ^ rx_sync_q) == PARITY_ODD);
          state_d  = RX_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          ferr_d  = ~rx_sync_q;
          perr_d  = PARITY_EN & ~par_ok_q;
          valid_d = rx_sync_q & (~PARITY_EN | par_ok_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign parity_err_o = perr_q;
  assign idle_o       = (state_q == RX_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_word_packer.sv
`default_nettype none
// ============================================================================
// | Module      : uart_word_packer                                           |
// | Description : UART-to-FIFO ingress. Packs received bytes into            |
// |               FIFO_WR_WIDTH-bit words in a selectable byte order, flushes|
// |               partial words after an idle timeout with per-lane keep,   |
// |               holds one pending word against FIFO backpressure and      |
// |               reports sticky frame/parity/overflow errors.              |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module uart_word_packer
  import uart_pkg::*;
#(
  parameter int         UART_BPS      = 9600,
  parameter int         CLK_FREQ      = 50_000_000,
  parameter int         FIFO_WR_WIDTH = 32,
  parameter int         FIFO_WR_BYTE  = FIFO_WR_WIDTH / 8,
  parameter int         BYTE_ORDER    = 0,
  parameter int         PARITY_EN     = 0,
  parameter int         PARITY_ODD    = 0,
  parameter int         TIMEOUT_BITS  = 40,
  parameter logic [7:0] PAD_BYTE      = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  input  logic                     fifo_full,
  input  logic                     err_clr,
  output logic [FIFO_WR_WIDTH-1:0] fifo_wr_data,
  output logic [FIFO_WR_BYTE-1:0]  fifo_wr_keep,
  output logic                     fifo_wr_en,
  output logic                     err_frame,
  output logic                     err_parity,
  output logic                     err_overflow
);

  localparam int BIT_CNT_MAX = bit_cnt_max(CLK_FREQ, UART_BPS);
  localparam int KW          = (FIFO_WR_BYTE > 1) ? $clog2(FIFO_WR_BYTE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(FIFO_WR_BYTE - 1);
  localparam logic [FIFO_WR_WIDTH-1:0] PAD_WORD = {FIFO_WR_BYTE{PAD_BYTE}};

  // Receiver interface
  logic [7:0] rx_byte;
  logic       rx_valid, rx_frame_err, rx_parity_err, rx_idle;

  uart_rx_core #(
    .CLK_FREQ   (CLK_FREQ),
    .UART_BPS   (UART_BPS),
    .PARITY_EN  (PARITY_EN != 0),
    .PARITY_ODD (PARITY_ODD != 0)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_frame_err),
    .parity_err_o (rx_parity_err),
    .idle_o       (rx_idle)
  );

  // Assembly state
  logic [FIFO_WR_WIDTH-1:0] asm_q, asm_d;
  logic [FIFO_WR_BYTE-1:0]  keep_q, keep_d;
  logic [KW-1:0]            k_q, k_d;

  // Pending slot (doubles as the FIFO-side output register)
  logic                     pend_valid_q, pend_valid_d;
  logic [FIFO_WR_WIDTH-1:0] pend_data_q, pend_data_d;
  logic [FIFO_WR_BYTE-1:0]  pend_keep_q, pend_keep_d;

  logic err_frame_q, err_parity_q, err_ovf_q;

  int                       w_lane;
  logic [FIFO_WR_WIDTH-1:0] w_word;
  logic [FIFO_WR_BYTE-1:0]  w_keep_set;
  logic                     w_push;
  logic [FIFO_WR_WIDTH-1:0] w_push_data;
  logic [FIFO_WR_BYTE-1:0]  w_push_keep;
  logic                     w_timeout;
  logic                     w_slot_free;
  logic                     w_ovf_set;

  // Idle-timeout counter: counts whole bit periods while idle with a partial word
  if (TIMEOUT_BITS > 0) begin : g_timeout
    localparam int TO_W = $clog2(TIMEOUT_BITS + 1);
    localparam int CW   = (BIT_CNT_MAX > 0) ? $clog2(BIT_CNT_MAX + 1) : 1;
    logic [CW-1:0]   cyc_q;
    logic [TO_W-1:0] bits_q;
    logic            w_count_en;

    assign w_count_en = rx_idle & (k_q != '0) & ~rx_valid;
    assign w_timeout  = w_count_en & (bits_q == TO_W'(TIMEOUT_BITS));

    // Any activity on the line or an empty word restarts the count from zero
    always_ff @(posedge clk) begin
      if (!rst_n || !w_count_en) begin
        cyc_q  <= '0;
        bits_q <= '0;
      end else if (cyc_q == CW'(BIT_CNT_MAX)) begin
        cyc_q  <= '0;
        bits_q <= bits_q + TO_W'(1);
      end else begin
        cyc_q  <= cyc_q + CW'(1);
      end
    end
  end else begin : g_no_timeout
    assign w_timeout = 1'b0;
  end

  // Merge the incoming byte into its lane of the assembly word
  always_comb begin
    w_lane     = (BYTE_ORDER == BYTE_ORDER_MSB) ? (FIFO_WR_BYTE - 1 - int'(k_q)) : int'(k_q);
    w_word     = asm_q;
    w_keep_set = keep_q;
    for (int i = 0; i < FIFO_WR_BYTE; i++) begin
      if (i == w_lane) begin
        w_word[8*i +: 8] = rx_byte;
        w_keep_set[i]    = 1'b1;
      end
    end
  end

  // Packer: full word or timeout flush produces a push toward the pending slot
  always_comb begin
    asm_d       = asm_q;
    keep_d      = keep_q;
    k_d         = k_q;
    w_push      = 1'b0;
    w_push_data = w_word;
    w_push_keep = w_keep_set;
    if (rx_valid) begin
      if (k_q == K_LAST) begin
        w_push      = 1'b1;
        w_push_keep = '1;
        asm_d       = PAD_WORD;
        keep_d      = '0;
        k_d         = '0;
      end else begin
        asm_d  = w_word;
        keep_d = w_keep_set;
        k_d    = k_q + KW'(1);
      end
    end else if (w_timeout) begin
      w_push      = 1'b1;
      w_push_data = asm_q;
      w_push_keep = keep_q;
      asm_d       = PAD_WORD;
      keep_d      = '0;
      k_d         = '0;
    end
  end

  assign fifo_wr_en  = pend_valid_q & ~fifo_full;
  // A slot draining this edge can take a new word on the same edge
  assign w_slot_free = ~pend_valid_q | fifo_wr_en;

  // Pending slot update and overflow detection
  always_comb begin
    pend_valid_d = pend_valid_q & ~fifo_wr_en;
    pend_data_d  = pend_data_q;
    pend_keep_d  = pend_keep_q;
    w_ovf_set    = 1'b0;
    if (w_push) begin
      if (w_slot_free) begin
        pend_valid_d = 1'b1;
        pend_data_d  = w_push_data;
        pend_keep_d  = w_push_keep;
      end else begin
        w_ovf_set = 1'b1;
      end
    end
  end

  // Packer and pending-slot registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_q        <= PAD_WORD;
      keep_q       <= '0;
      k_q          <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_keep_q  <= '0;
    end else begin
      asm_q        <= asm_d;
      keep_q       <= keep_d;
      k_q          <= k_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_keep_q  <= pend_keep_d;
    end
  end

  // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_frame_q  <= 1'b0;
      err_parity_q <= 1'b0;
      err_ovf_q    <= 1'b0;
    end else begin
      err_frame_q  <= (err_frame_q  & ~err_clr) | rx_frame_err;
      err_parity_q <= (err_parity_q & ~err_clr) | rx_parity_err;
      err_ovf_q    <= (err_ovf_q    & ~err_clr) | w_ovf_set;
    end
  end

  assign fifo_wr_data = pend_data_q;
  assign fifo_wr_keep = pend_keep_q;
  assign err_frame    = err_frame_q;
  assign err_parity   = err_parity_q;
  assign err_overflow = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_word_packer.sv
`default_nettype none
// ============================================================================
// | Module      : tb_uart_word_packer                                        |
// | Description : Self-checking bench for uart_word_packer. Three instances: |
// |               MSB-first, LSB-first, and MSB-first with even parity.     |
// |               Baud is 20 clocks per bit to keep runs short.             |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
module tb_uart_word_packer;

  localparam int CLK_FREQ = 50_000_000;
  localparam int UART_BPS = 2_500_000;
  localparam int BIT_CLKS = CLK_FREQ / UART_BPS;

  logic clk = 1'b0;
  logic rst_n, fifo_full, err_clr;
  logic rx0, rx1, rx2;

  logic [31:0] data0, data1, data2;
  logic [3:0]  keep0, keep1, keep2;
  logic        en0, en1, en2;
  logic        ef0, ef1, ef2, ep0, ep1, ep2, eo0, eo1, eo2;

  always #5 clk = ~clk;

  uart_word_packer #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ), .BYTE_ORDER(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .fifo_full(fifo_full), .err_clr(err_clr),
    .fifo_wr_data(data0), .fifo_wr_keep(keep0), .fifo_wr_en(en0),
    .err_frame(ef0), .err_parity(ep0), .err_overflow(eo0));

  uart_word_packer #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ), .BYTE_ORDER(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .fifo_full(fifo_full), .err_clr(err_clr),
    .fifo_wr_data(data1), .fifo_wr_keep(keep1), .fifo_wr_en(en1),
    .err_frame(ef1), .err_parity(ep1), .err_overflow(eo1));

  uart_word_packer #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ), .BYTE_ORDER(0),
                     .PARITY_EN(1), .PARITY_ODD(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx(rx2), .fifo_full(fifo_full), .err_clr(err_clr),
    .fifo_wr_data(data2), .fifo_wr_keep(keep2), .fifo_wr_en(en2),
    .err_frame(ef2), .err_parity(ep2), .err_overflow(eo2));

  int checks = 0;
  int errors = 0;

  // Write logs: {data, keep} captured on every cycle with a write strobe
  logic [35:0] wq0[$];
  logic [35:0] wq1[$];
  logic [35:0] wq2[$];

  always @(negedge clk) begin
    if (en0) wq0.push_back({data0, keep0});
    if (en1) wq1.push_back({data1, keep1});
    if (en2) wq2.push_back({data2, keep2});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return wq0.size();
      1:       return wq1.size();
      default: return wq2.size();
    endcase
  endfunction

  task automatic clear_logs;
    wq0.delete();
    wq1.delete();
    wq2.delete();
  endtask

  task automatic expect_write(input string name, input int d,
                              input logic [31:0] ed, input logic [3:0] ek);
    logic [35:0] e;
    logic        got;
    got = 1'b0;
    e   = '0;
    case (d)
      0: if (wq0.size() > 0) begin e = wq0.pop_front(); got = 1'b1; end
      1: if (wq1.size() > 0) begin e = wq1.pop_front(); got = 1'b1; end
      default: if (wq2.size() > 0) begin e = wq2.pop_front(); got = 1'b1; end
    endcase
    check({name, " written"}, 32'(got), 32'd1);
    if (got) begin
      check({name, " data"}, e[35:4], ed);
      check({name, " keep"}, 32'(e[3:0]), 32'(ek));
    end
  endtask

  task automatic drive_rx(input int d, input logic v);
    case (d)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic hold_bit(input int d, input logic v);
    drive_rx(d, v);
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Instance 2 carries an even-parity bit; bad_par inverts it
  task automatic send_byte(input int d, input logic [7:0] b,
                           input logic bad_par = 1'b0, input logic stop = 1'b1);
    hold_bit(d, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d, b[i]);
    if (d == 2) hold_bit(d, (^b) ^ bad_par);
    hold_bit(d, stop);
    drive_rx(d, 1'b1);
  endtask

  task automatic send_word(input int d, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(d, w[31-8*i -: 8]);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic pulse_clr;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    int          dut;
    logic [31:0] bytes;     // first-sent byte in [31:24]
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 32'h12345678, 32'h12345678, 4'hF};
    vecs[1] = '{1, 32'h12345678, 32'h78563412, 4'hF};
    vecs[2] = '{0, 32'hDEADBEEF, 32'hDEADBEEF, 4'hF};
    vecs[3] = '{1, 32'h01020304, 32'h04030201, 4'hF};
    vecs[4] = '{2, 32'hA53C00FF, 32'hA53C00FF, 4'hF};

    rst_n = 1'b0; fifo_full = 1'b0; err_clr = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    repeat (5) @(negedge clk);

    // Reset state
    check("rst data", data0, 32'h0);
    check("rst keep", 32'(keep0), 32'h0);
    check("rst wr_en", 32'(en0), 32'h0);
    check("rst err_frame", 32'(ef0), 32'h0);
    check("rst err_parity", 32'(ep0), 32'h0);
    check("rst err_overflow", 32'(eo0), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven full words across byte orders and parity
    for (int i = 0; i < 5; i++) begin
      clear_logs();
      send_word(vecs[i].dut, vecs[i].bytes);
      repeat (5) @(negedge clk);
      expect_write($sformatf("vec%0d", i), vecs[i].dut, vecs[i].exp_data, vecs[i].exp_keep);
      check($sformatf("vec%0d extra", i), 32'(qsize(vecs[i].dut)), 32'd0);
    end

    // Back-to-back words with no gap, LSB-first
    clear_logs();
    send_word(1, 32'h11223344);
    send_word(1, 32'h55667788);
    repeat (5) @(negedge clk);
    expect_write("b2b w1", 1, 32'h44332211, 4'hF);
    expect_write("b2b w2", 1, 32'h88776655, 4'hF);

    // Idle timeout flushes a partial word
    clear_logs();
    send_byte(0, 8'hAA);
    send_byte(0, 8'hBB);
    idle_bits(30);
    check("timeout early", 32'(qsize(0)), 32'd0);
    idle_bits(15);
    expect_write("timeout flush", 0, 32'hAABB0000, 4'b1100);
    send_word(0, 32'h01020304);
    repeat (5) @(negedge clk);
    expect_write("after flush", 0, 32'h01020304, 4'hF);
    idle_bits(50);
    check("no flush at k=0", 32'(qsize(0)), 32'd0);

    // Parity error drops the byte without advancing the lane index
    clear_logs();
    send_byte(2, 8'h11);
    send_byte(2, 8'h01, 1'b1);
    repeat (3) @(negedge clk);
    check("parity err set", 32'(ep2), 32'd1);
    check("parity no frame err", 32'(ef2), 32'd0);
    send_byte(2, 8'h22);
    send_byte(2, 8'h33);
    send_byte(2, 8'h44);
    repeat (5) @(negedge clk);
    expect_write("parity word", 2, 32'h11223344, 4'hF);
    check("parity sticky", 32'(ep2), 32'd1);
    pulse_clr();
    check("parity cleared", 32'(ep2), 32'd0);

    // Frame error: stop bit low
    clear_logs();
    send_byte(0, 8'h55, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("frame err set", 32'(ef0), 32'd1);
    check("frame no write", 32'(qsize(0)), 32'd0);
    pulse_clr();
    check("frame cleared", 32'(ef0), 32'd0);

    // Backpressure: second word lost while slot held
    clear_logs();
    fifo_full = 1'b1;
    send_word(0, 32'hCAFEF00D);
    send_word(0, 32'h0BADBEEF);
    repeat (5) @(negedge clk);
    check("full no write", 32'(qsize(0)), 32'd0);
    check("overflow set", 32'(eo0), 32'd1);
    check("full data held", data0, 32'hCAFEF00D);
    fifo_full = 1'b0;
    repeat (10) @(negedge clk);
    expect_write("release", 0, 32'hCAFEF00D, 4'hF);
    check("release single", 32'(qsize(0)), 32'd0);
    pulse_clr();
    check("overflow cleared", 32'(eo0), 32'd0);

    // Reset in the middle of the third byte discards the partial word
    clear_logs();
    send_byte(0, 8'h77);
    send_byte(0, 8'h66);
    hold_bit(0, 1'b0);
    hold_bit(0, 1'b1);
    hold_bit(0, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rx0 = 1'b1;
    rst_n = 1'b1;
    idle_bits(2);
    check("midrst no write", 32'(qsize(0)), 32'd0);
    check("midrst keep", 32'(keep0), 32'h0);
    send_word(0, 32'h9ABCDEF0);
    repeat (5) @(negedge clk);
    expect_write("midrst word", 0, 32'h9ABCDEF0, 4'hF);
    idle_bits(50);
    check("midrst single", 32'(qsize(0)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
